// File: rtl/fifo_burst_writer.sv
// Burst writer for the sensor-path FIFO: writes BURST_LEN patterned words,
// stalls on full, supervises write_ack with a timeout and latches faults.
// Optional build macro: FIFO_BURST_WRITER_STALL_STATS_EN (stall/ack-latency stats).
module fifo_burst_writer #(
    parameter int DATA_W      = 8,
    parameter int BURST_LEN   = 2,
    parameter int PATTERN     = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    input  logic [DATA_W-1:0] seed,
    output logic              done,
    output logic              busy,
    output logic              error,
    output logic [15:0]       words_written,
    output logic [DATA_W-1:0] data_out,
    output logic              write_en,
    output logic              ext_reset,
    input  logic              full,
    input  logic              write_ack,
    input  logic              overflow
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [7:0]        max_ack_latency
`endif
);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, DONE, ERROR} state_t;

    state_t            state;
    logic [DATA_W-1:0] seed_q;
    logic [7:0]        tcnt;
    logic [DATA_W-1:0] pat;
    logic [15:0]       ww_next;
    logic              timed_out;

    always_comb begin
        pat = seed_q + DATA_W'(words_written);
        if (PATTERN == 1)
            pat = words_written[0] ? ~seed_q : seed_q;
    end

    assign ww_next   = words_written + 16'd1;
    // This cycle is the ACK_TIMEOUT-th WAIT_ACK cycle without an ack.
    assign timed_out = ({1'b0, tcnt} + 9'd1) >= 9'(ACK_TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ext_reset     <= 1'b1;
            done          <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            write_en      <= 1'b0;
            data_out      <= '0;
            words_written <= '0;
            tcnt          <= '0;
            seed_q        <= '0;
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
            stall_cycles    <= '0;
            max_ack_latency <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ext_reset <= 1'b1;
                    data_out  <= '0;
                    done      <= 1'b0;
                    if (start) begin
                        seed_q        <= seed;
                        words_written <= '0;
                        ext_reset     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= CHECK;
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
                        stall_cycles    <= '0;
                        max_ack_latency <= '0;
`endif
                    end
                end
                CHECK: state <= ISSUE;
                ISSUE: begin
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
                    if (full && stall_cycles != 16'hFFFF)
                        stall_cycles <= stall_cycles + 16'd1;
`endif
                    if (overflow) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        write_en <= 1'b0;
                        state    <= ERROR;
                    end else if (full) begin
                        write_en <= 1'b0;
                    end else begin
                        write_en <= 1'b1;
                        data_out <= pat;
                        tcnt     <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    write_en <= 1'b0;
                    // Overflow wins over a same-cycle ack; that word is not counted.
                    if (overflow) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERROR;
                    end else if (write_ack) begin
                        words_written <= ww_next;
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
                        if (tcnt + 8'd1 > max_ack_latency)
                            max_ack_latency <= tcnt + 8'd1;
`endif
                        if (ww_next == 16'(BURST_LEN)) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            data_out <= '0;
                            state    <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (timed_out) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ERROR;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (restart) begin
                        ext_reset <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERROR: begin
                    write_en <= 1'b0;
                    if (restart) begin
                        error     <= 1'b0;
                        ext_reset <= 1'b1;
                        data_out  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer: several parameter configurations side by
// side; expected write data is queued by stimulus and popped by a write monitor.
module tb_fifo_burst_writer;

    localparam int NI = 5;
    localparam int LENS [NI] = '{2, 4, 2, 8, 1};
    localparam int PATS [NI] = '{0, 1, 0, 0, 0};
    localparam int TOS  [NI] = '{15, 15, 4, 15, 15};

    typedef struct {
        int         inst;
        logic [7:0] d;
    } exp_t;

    logic                 clk;
    logic [NI-1:0]        rst, start, restart, full, overflow;
    logic [NI-1:0]        ack_en, man_ack, resp_ack, pend, write_ack;
    logic [NI-1:0][7:0]   seed;
    logic [NI-1:0]        done, busy, error, write_en, ext_reset;
    logic [NI-1:0][15:0]  ww;
    logic [NI-1:0][7:0]   dout;
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
    logic [NI-1:0][15:0]  stall_cycles;
    logic [NI-1:0][7:0]   max_lat;
`endif

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    assign write_ack = resp_ack | man_ack;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fifo_burst_writer #(
            .DATA_W(8), .BURST_LEN(LENS[g]), .PATTERN(PATS[g]), .ACK_TIMEOUT(TOS[g])
        ) dut (
            .clk(clk), .reset(rst[g]), .start(start[g]), .restart(restart[g]),
            .seed(seed[g]), .done(done[g]), .busy(busy[g]), .error(error[g]),
            .words_written(ww[g]), .data_out(dout[g]), .write_en(write_en[g]),
            .ext_reset(ext_reset[g]), .full(full[g]), .write_ack(write_ack[g]),
            .overflow(overflow[g])
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
            , .stall_cycles(stall_cycles[g]), .max_ack_latency(max_lat[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        exp_t e;
        e.inst = i;
        e.d    = d;
        q.push_back(e);
    endtask

    // FIFO model: ack one cycle after it sees write_en.
    initial begin
        resp_ack = '0;
        pend     = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = pend & ack_en;
            pend     = write_en & ack_en;
        end
    end

    // Write monitor: every write_en cycle must match the next queued word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (write_en[i]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected write inst%0d", i), {24'd0, dout[i]}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("write inst%0d", i), {i[15:0], 8'd0, dout[i]},
                            {e.inst[15:0], 8'd0, e.d});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input int i, input logic [7:0] s);
        seed[i]  = s;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string name);
        int k = 0;
        while (!done[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done seen"}, {31'd0, done[i]}, 32'd1);
        @(negedge clk);
        chk({name, " done one cycle"}, {31'd0, done[i]}, 32'd0);
        chk({name, " busy after done"}, {31'd0, busy[i]}, 32'd0);
    endtask

    task automatic do_restart(input int i, input string name);
        restart[i] = 1'b1;
        @(negedge clk);
        restart[i] = 1'b0;
        @(negedge clk);
        chk({name, " ext_reset after restart"}, {31'd0, ext_reset[i]}, 32'd1);
        chk({name, " error after restart"}, {31'd0, error[i]}, 32'd0);
    endtask

    task automatic wait_we(input int i, input string name);
        int k = 0;
        while (!write_en[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " write_en seen"}, {31'd0, write_en[i]}, 32'd1);
    endtask

    initial begin
        int k;
        rst = '1; start = '0; restart = '0; full = '0; overflow = '0;
        ack_en = '0; man_ack = '0; seed = '0;
        repeat (3) @(negedge clk);
        chk("reset ext_reset", {31'd0, ext_reset[0]}, 32'd1);
        chk("reset busy/done/error/we", {28'd0, busy[0], done[0], error[0], write_en[0]}, 32'd0);
        chk("reset data_out", {24'd0, dout[0]}, 32'd0);
        chk("reset words_written", {16'd0, ww[0]}, 32'd0);
        rst = '0;
        @(negedge clk);

        // 1: increment pattern, two words
        ack_en[0] = 1'b1;
        push(0, 8'hAA); push(0, 8'hAB);
        do_start(0, 8'hAA);
        chk("t1 ext_reset falls", {31'd0, ext_reset[0]}, 32'd0);
        chk("t1 busy", {31'd0, busy[0]}, 32'd1);
        wait_done(0, "t1");
        chk("t1 words_written", {16'd0, ww[0]}, 32'd2);
        chk("t1 data_out in DONE", {24'd0, dout[0]}, 32'd0);
        do_restart(0, "t1");

        // 2: alternate pattern with a 3-cycle full stall before word 2
        ack_en[1] = 1'b1;
        push(1, 8'h5A); push(1, 8'hA5); push(1, 8'h5A); push(1, 8'hA5);
        do_start(1, 8'h5A);
        k = 0;
        while (ww[1] != 16'd1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t2 reached word 2", {16'd0, ww[1]}, 32'd1);
        full[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t2 stalled write_en", {31'd0, write_en[1]}, 32'd0);
            chk("t2 stalled busy", {31'd0, busy[1]}, 32'd1);
        end
        full[1] = 1'b0;
        wait_done(1, "t2");
        chk("t2 words_written", {16'd0, ww[1]}, 32'd4);
`ifdef FIFO_BURST_WRITER_STALL_STATS_EN
        chk("t2 stall_cycles", {16'd0, stall_cycles[1]}, 32'd3);
        chk("t2 max_ack_latency", {24'd0, max_lat[1]}, 32'd2);
`endif
        do_restart(1, "t2");

        // 3: ack timeout of 4 cycles
        push(2, 8'h33);
        do_start(2, 8'h33);
        wait_we(2, "t3");
        k = 0;
        while (!error[2] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t3 cycles to error", k, 32'd4);
        chk("t3 error", {31'd0, error[2]}, 32'd1);
        chk("t3 words_written", {16'd0, ww[2]}, 32'd0);
        chk("t3 busy", {31'd0, busy[2]}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t3 error sticky", {31'd0, error[2]}, 32'd1);
        do_restart(2, "t3");

        // 4: overflow together with ack on word 1
        ack_en[0] = 1'b0;
        push(0, 8'h10);
        do_start(0, 8'h10);
        wait_we(0, "t4");
        man_ack[0]  = 1'b1;
        overflow[0] = 1'b1;
        @(negedge clk);
        man_ack[0]  = 1'b0;
        overflow[0] = 1'b0;
        chk("t4 error", {31'd0, error[0]}, 32'd1);
        chk("t4 words_written", {16'd0, ww[0]}, 32'd0);
        do_restart(0, "t4");

        // 5: reset during WAIT_ACK of word 3 of 8, then a fresh burst
        ack_en[3] = 1'b1;
        push(3, 8'h20); push(3, 8'h21); push(3, 8'h22);
        do_start(3, 8'h20);
        k = 0;
        while (!(ww[3] == 16'd2 && write_en[3]) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5 in word 3", {15'd0, write_en[3], ww[3]}, {15'd0, 1'b1, 16'd2});
        rst[3] = 1'b1;
        @(negedge clk);
        rst[3] = 1'b0;
        chk("t5 reset ext_reset", {31'd0, ext_reset[3]}, 32'd1);
        chk("t5 reset flags", {28'd0, busy[3], done[3], error[3], write_en[3]}, 32'd0);
        chk("t5 reset words/data", {8'd0, ww[3], dout[3]}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t5 no write after reset", {16'd0, ww[3]}, 32'd0);
        for (int w = 0; w < 8; w++) push(3, 8'h40 + 8'(w));
        do_start(3, 8'h40);
        wait_done(3, "t5");
        chk("t5 words_written", {16'd0, ww[3]}, 32'd8);
        do_restart(3, "t5");

        // 6: single-word burst, then wrap-around on a 2-word burst
        ack_en[4] = 1'b1;
        push(4, 8'hFF);
        do_start(4, 8'hFF);
        wait_done(4, "t6a");
        chk("t6a words_written", {16'd0, ww[4]}, 32'd1);
        ack_en[0] = 1'b1;
        push(0, 8'hFF); push(0, 8'h00);
        do_start(0, 8'hFF);
        wait_done(0, "t6b");
        chk("t6b words_written", {16'd0, ww[0]}, 32'd2);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
